// File: rtl/terrain_crater_writer.sv
// terrain_crater_writer
//   Carves a circular crater into the per-column terrain bitmaps. For every
//   column x in [max(cx-r,0), min(cx+r,COLS-1)] it reads the column word,
//   finds the half-height h of the circle at that column, clears the bits
//   cy-h..cy+h that lie in 0..ROWS-1, and writes the word back inside the
//   display write window.
//
// Ports
//   clk_i, reset_i   system clock, synchronous active-high reset
//   start_i          crater request (sampled in IDLE only)
//   cx_i, cy_i       crater centre column / row
//   radius_i         crater radius in pixels
//   busy_o           crater in progress
//   done_o           one-cycle completion pulse
//   rd_addr_o        column address to the terrain read port
//   rd_data_i        column word, valid one cycle after rd_addr_o
//   wr_allow_i       write window; writes only happen while it is high
//   wr_en_o          one-cycle column write strobe
//   wr_addr_o        column address of the write
//   wr_data_o        modified column word
module terrain_crater_writer #(
  parameter int COLS   = 640,
  parameter int ROWS   = 480,
  parameter int DATA_W = 512,
  parameter int R_W    = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [9:0]        cx_i,
  input  logic [9:0]        cy_i,
  input  logic [R_W-1:0]    radius_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [9:0]        rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              wr_allow_i,
  output logic              wr_en_o,
  output logic [9:0]        wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);

  localparam int SQ_W = 2 * R_W;

  localparam logic [9:0]  COLS_A  = 10'(COLS);
  localparam logic [11:0] COLS_M1 = 12'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_READ, S_WAIT, S_CALC, S_WRITE, S_NEXT, S_FIN
  } state_e;

  state_e state_q, state_d;

  logic [9:0]        cx_q, cy_q;
  logic [R_W-1:0]    r_q;
  logic [9:0]        x_q, x_hi_q;
  logic [R_W-1:0]    h_q;
  logic [DATA_W-1:0] col_q;

  // ---------------------------------------------------------------------
  // Column range. Worked in 12-bit signed so cx-r below zero does not wrap.
  // ---------------------------------------------------------------------
  logic [11:0]        r_ext, h_ext;
  logic signed [11:0] x_lo_s;
  logic [11:0]        x_hi_full;
  logic [9:0]         x_lo, x_hi;

  assign r_ext     = {{(12-R_W){1'b0}}, r_q};
  assign h_ext     = {{(12-R_W){1'b0}}, h_q};
  assign x_lo_s    = signed'({2'b00, cx_q}) - signed'(r_ext);
  assign x_hi_full = {2'b00, cx_q} + r_ext;
  assign x_lo      = (x_lo_s < 0) ? 10'd0 : x_lo_s[9:0];
  assign x_hi      = (x_hi_full > COLS_M1) ? COLS_M1[9:0] : x_hi_full[9:0];

  // ---------------------------------------------------------------------
  // Half-height search. h walks down from r until h^2 + dx^2 <= r^2.
  // dx never exceeds r because x stays inside [cx-r, cx+r], so the
  // truncation to R_W bits is lossless.
  // ---------------------------------------------------------------------
  logic [R_W-1:0]  dx;
  logic [SQ_W-1:0] h_sq, dx_sq, r_sq;
  logic [SQ_W:0]   sum_sq;
  logic            shrink;

  assign dx     = R_W'((x_q >= cx_q) ? (x_q - cx_q) : (cx_q - x_q));
  assign h_sq   = SQ_W'(h_q) * SQ_W'(h_q);
  assign dx_sq  = SQ_W'(dx)  * SQ_W'(dx);
  assign r_sq   = SQ_W'(r_q) * SQ_W'(r_q);
  assign sum_sq = (SQ_W+1)'(h_sq) + (SQ_W+1)'(dx_sq);
  assign shrink = sum_sq > (SQ_W+1)'(r_sq);

  // ---------------------------------------------------------------------
  // Clear mask: bit y is cleared when cy-h <= y <= cy+h. The lower bound
  // is signed, so a negative cy-h simply admits every y from 0. Bits at
  // ROWS and above are padding and are never touched.
  // ---------------------------------------------------------------------
  logic signed [11:0] y_lo_s, y_hi_s;
  logic [DATA_W-1:0]  clr;

  assign y_lo_s = signed'({2'b00, cy_q}) - signed'(h_ext);
  assign y_hi_s = signed'({2'b00, cy_q} + h_ext);

  for (genvar g = 0; g < DATA_W; g++) begin : g_mask
    if (g < ROWS) begin : g_row
      localparam logic signed [11:0] YV = 12'(g);
      assign clr[g] = (YV >= y_lo_s) && (YV <= y_hi_s);
    end else begin : g_pad
      assign clr[g] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    wr_en_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_SETUP;
      end
      S_SETUP: begin
        busy_o  = 1'b1;
        // A centre off the right edge produces no columns at all.
        state_d = (cx_q >= COLS_A) ? S_FIN : S_READ;
      end
      S_READ: begin
        busy_o  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy_o  = 1'b1;
        state_d = S_CALC;
      end
      S_CALC: begin
        busy_o = 1'b1;
        if (!shrink) state_d = S_WRITE;
      end
      S_WRITE: begin
        busy_o = 1'b1;
        if (wr_allow_i) begin
          // A reset in this very cycle must not leak a half-finished write.
          wr_en_o = !reset_i;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        busy_o  = 1'b1;
        state_d = (x_q == x_hi_q) ? S_FIN : S_READ;
      end
      S_FIN: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cx_q   <= '0;
      cy_q   <= '0;
      r_q    <= '0;
      x_q    <= '0;
      x_hi_q <= '0;
      h_q    <= '0;
      col_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cx_q <= cx_i;
            cy_q <= cy_i;
            r_q  <= radius_i;
          end
        end
        S_SETUP: begin
          x_q    <= x_lo;
          x_hi_q <= x_hi;
        end
        S_WAIT: begin
          col_q <= rd_data_i;
          h_q   <= r_q;
        end
        S_CALC: begin
          if (shrink) h_q   <= h_q - R_W'(1);
          else        col_q <= col_q & ~clr;
        end
        S_NEXT: begin
          if (x_q != x_hi_q) x_q <= x_q + 10'd1;
        end
        default: ;
      endcase
    end
  end

  // The column register already holds the carved word once WRITE is reached.
  assign rd_addr_o = x_q;
  assign wr_addr_o = x_q;
  assign wr_data_o = col_q;

endmodule

// File: tb/tb_terrain_crater_writer.sv
module tb_terrain_crater_writer;
  localparam int COLS   = 640;
  localparam int ROWS   = 480;
  localparam int DATA_W = 512;
  localparam int R_W    = 6;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [9:0]        cx, cy;
  logic [R_W-1:0]    radius;
  logic              busy, done;
  logic [9:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_allow;
  logic              wr_en;
  logic [9:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;

  terrain_crater_writer #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W), .R_W(R_W)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .cx_i(cx), .cy_i(cy),
    .radius_i(radius), .busy_o(busy), .done_o(done), .rd_addr_o(rd_addr),
    .rd_data_i(rd_data), .wr_allow_i(wr_allow), .wr_en_o(wr_en),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data)
  );

  always #5 clk = ~clk;

  // Terrain store: contents set by the test, one-cycle read latency.
  logic [DATA_W-1:0] mem [COLS];
  always @(posedge clk)
    rd_data <= (int'(rd_addr) < COLS) ? mem[rd_addr] : '0;

  // Write window: either forced by the test or random.
  logic allow_rand, allow_force;
  always begin
    @(posedge clk);
    #1;
    wr_allow = allow_rand ? 1'($urandom_range(0, 1)) : allow_force;
  end

  typedef struct {
    int                addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t wlog[$];   // every write seen on the port
  wr_t exp_q[$];  // expected writes of the current crater

  always @(negedge clk)
    if (wr_en === 1'b1) wlog.push_back('{int'(wr_addr), wr_data});

  int n_tests, n_fail;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: every column whose distance from the centre is within r,
  // inside the screen, gets the tallest half-height h with h^2+dx^2 <= r^2,
  // and rows |y-cy| <= h below ROWS are cleared.
  function automatic void build_exp(input int mcx, input int mcy, input int mr);
    exp_q.delete();
    if (mcx >= COLS) return;
    for (int x = 0; x < COLS; x++) begin
      int dx;
      int h;
      logic [DATA_W-1:0] w;
      dx = x - mcx;
      if (dx * dx > mr * mr) continue;
      h = 0;
      for (int k = 0; k <= mr; k++)
        if (k * k + dx * dx <= mr * mr) h = k;
      w = mem[x];
      for (int y = 0; y < ROWS; y++)
        if (y >= mcy - h && y <= mcy + h) w[y] = 1'b0;
      exp_q.push_back('{x, w});
    end
  endfunction

  task automatic fill_ones();
    for (int x = 0; x < COLS; x++) mem[x] = '1;
  endtask

  task automatic fill_rand();
    for (int x = 0; x < COLS; x++)
      for (int w = 0; w < DATA_W / 32; w++) mem[x][w*32 +: 32] = $urandom;
  endtask

  task automatic pulse_start(input int mcx, input int mcy, input int mr);
    @(posedge clk); #1;
    start = 1'b1; cx = 10'(mcx); cy = 10'(mcy); radius = R_W'(mr);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Bounded wait for done; returns 1 if it was seen.
  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    chk_int("done_within_budget", 32'(seen), 1);
  endtask

  task automatic cmp_log(input int base);
    int nwr;
    nwr = wlog.size() - base;
    chk_int("write_count", nwr, exp_q.size());
    for (int i = 0; i < nwr && i < exp_q.size(); i++) begin
      chk_int("wr_addr", wlog[base+i].addr, exp_q[i].addr);
      chk("wr_data", wlog[base+i].data, exp_q[i].data);
    end
  endtask

  task automatic run(input int mcx, input int mcy, input int mr, output int base);
    bit seen;
    build_exp(mcx, mcy, mr);
    base = wlog.size();
    pulse_start(mcx, mcy, mr);
    chk_int("busy_after_start", 32'(busy), 1);
    wait_done(20000, seen);
    if (seen) begin
      chk_int("busy_low_at_done", 32'(busy), 0);
      @(negedge clk);
      chk_int("done_single_pulse", 32'(done), 0);
    end
    cmp_log(base);
  endtask

  typedef struct {
    int cx, cy, r;
    int nwr, first, last;
    int probe, plo, phi;   // probe column, expected cleared rows plo..phi
  } vec_t;

  vec_t vt[8];

  initial begin
    int base, nwr, idx;
    bit seen, pad_ok, range_ok;
    logic [DATA_W-1:0] pw;

    n_tests = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; cx = '0; cy = '0; radius = '0;
    allow_rand = 1'b0; allow_force = 1'b1;
    fill_ones();

    vt[0] = '{100, 200, 0,  1, 100, 100, 100, 200, 200};
    vt[1] = '{ 10,  50, 3,  7,   7,  13,  10,  47,  53};
    vt[2] = '{ 10,  50, 3,  7,   7,  13,   8,  48,  52};
    vt[3] = '{ 10,  50, 3,  7,   7,  13,   7,  50,  50};
    vt[4] = '{  1, 100, 5,  7,   0,   6,   0,  96, 104};
    vt[5] = '{300, 478, 4,  9, 296, 304, 300, 474, 479};
    vt[6] = '{639,  10, 5,  6, 634, 639, 639,   5,  15};
    vt[7] = '{ 50, 600, 3,  7,  47,  53,  50,   1,   0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_int("reset_busy", 32'(busy), 0);
    chk_int("reset_done", 32'(done), 0);
    chk_int("reset_wr_en", 32'(wr_en), 0);
    chk_int("reset_rd_addr", 32'(rd_addr), 0);
    chk_int("reset_wr_addr", 32'(wr_addr), 0);
    chk("reset_wr_data", wr_data, '0);

    // Table of fixed craters on an all-ones terrain.
    for (int i = 0; i < 8; i++) begin
      run(vt[i].cx, vt[i].cy, vt[i].r, base);
      nwr = wlog.size() - base;
      chk_int("tbl_nwr", nwr, vt[i].nwr);
      if (nwr > 0) begin
        chk_int("tbl_first", wlog[base].addr, vt[i].first);
        chk_int("tbl_last", wlog[wlog.size()-1].addr, vt[i].last);
      end
      pad_ok = 1'b1; range_ok = 1'b1; idx = -1;
      for (int j = base; j < wlog.size(); j++) begin
        if (wlog[j].data[DATA_W-1:ROWS] !== '1) pad_ok = 1'b0;
        if (wlog[j].addr >= COLS) range_ok = 1'b0;
        if (wlog[j].addr == vt[i].probe) idx = j;
      end
      chk_int("tbl_pad_bits_kept", 32'(pad_ok), 1);
      chk_int("tbl_addr_in_range", 32'(range_ok), 1);
      pw = '1;
      for (int y = vt[i].plo; y <= vt[i].phi; y++) pw[y] = 1'b0;
      chk_int("tbl_probe_found", 32'(idx >= 0), 1);
      if (idx >= 0) chk("tbl_probe_word", wlog[idx].data, pw);
    end

    // Off-screen centre: no writes at all.
    run(700, 10, 5, base);
    chk_int("offscreen_nwr", wlog.size() - base, 0);

    // Write window held closed, plus a start while busy.
    fill_ones();
    build_exp(20, 100, 2);
    base = wlog.size();
    allow_force = 1'b0;
    pulse_start(20, 100, 2);
    repeat (50) @(negedge clk);
    pulse_start(400, 300, 10);
    repeat (50) @(negedge clk);
    chk_int("gated_no_write", wlog.size() - base, 0);
    chk_int("gated_busy", 32'(busy), 1);
    chk_int("gated_wr_en", 32'(wr_en), 0);
    allow_force = 1'b1;
    wait_done(2000, seen);
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk_int("ignored_start_no_second_crater", 32'(seen), 0);
    cmp_log(base);

    // Reset while the first column of a large crater is in its search.
    base = wlog.size();
    pulse_start(200, 200, 20);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk_int("midreset_busy", 32'(busy), 0);
    chk_int("midreset_done", 32'(done), 0);
    chk_int("midreset_wr_en", 32'(wr_en), 0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk_int("midreset_no_write", wlog.size() - base, 0);
    run(200, 200, 20, base);

    // Random craters on random terrain with a random write window.
    allow_rand = 1'b1;
    for (int i = 0; i < 12; i++) begin
      fill_rand();
      run(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
          int'($urandom_range(0, 63)), base);
    end
    allow_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/terrain_crater_writer.md
Name: terrain_crater_writer

Overview:
Write-side client of the terrain column memory. On an explosion request it carves a circular crater into the per-column terrain bitmaps. For each affected column it reads the column, clears the bits that fall inside the circle, and writes the column back. It sits between the player/bomb logic, which issues the request, and the terrain store's write port. The display read path stays untouched.

Parameters:
COLS, 640, number of terrain columns (valid x range 0..COLS-1)
ROWS, 480, number of valid rows per column (bits 0..ROWS-1)
DATA_W, 512, column word width; bits ROWS..DATA_W-1 are never modified
R_W, 6, radius width (max radius 63)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
start  in  1  crater request; sampled only when busy=0
cx  in  10  crater centre column
cy  in  10  crater centre row
radius  in  R_W  crater radius in pixels
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the crater is complete
rd_addr  out  10  column address to the terrain writer-side read port
rd_data  in  DATA_W  column data, valid 1 cycle after rd_addr
wr_allow  in  1  write window from the display/blank logic; writes happen only while it is high
wr_en  out  1  one-cycle column write strobe
wr_addr  out  10  column address for the write
wr_data  out  DATA_W  modified column word

Behaviour:
- Reset values: busy=0, done=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0; FSM enters IDLE.
- Reset asserted in any state: FSM returns to IDLE on the next edge. Any pending write is dropped; no partial write is issued.
- FSM states: IDLE, SETUP, READ, WAIT, CALC, WRITE, NEXT, FIN.
- IDLE: start=1 latches cx, cy and radius into r, then goes to SETUP. busy rises the next cycle. start while busy=1 is ignored, not queued.
- SETUP:
  - x_lo = max(cx-r, 0), computed signed so there is no wrap.
  - x_hi = min(cx+r, COLS-1).
  - If cx >= COLS, go to FIN with no writes. Otherwise x = x_lo and go to READ.
- READ: rd_addr = x. WAIT: capture rd_data into the column register. Read latency is fixed at 1 cycle.
- CALC:
  - dx = |x-cx|; h initialised to r.
  - Each cycle: if h*h + dx*dx > r*r, decrement h. Otherwise the mask is final; go to WRITE.
  - Takes at most r+1 cycles. Products are 12-bit unsigned with a 13-bit sum, so there is no overflow.
- Mask: clear bit y iff cy-h <= y <= cy+h and 0 <= y < ROWS. The lower bound is computed signed, clipped at 0. All other bits pass through from rd_data unchanged.
- WRITE:
  - While wr_allow=0, hold the state with wr_en=0.
  - The first cycle wr_allow=1: wr_en=1 for exactly one cycle, with wr_addr=x and wr_data=modified word stable in that cycle. Then go to NEXT.
- NEXT: if x == x_hi go to FIN; otherwise x = x+1 and go to READ.
- FIN: done=1 for one cycle, busy=0 in that same cycle, then IDLE. A start in the cycle after done is accepted.
- Exactly one write per column in x_lo..x_hi, in ascending order. Writes are never outside 0..COLS-1.
- r=0 is legal: a single column write clearing only bit cy, if cy < ROWS.
- cy >= ROWS, or a circle entirely below ROWS: columns are still rewritten, with data unchanged.

Test Plan:
1. Single-pixel crater. start with cx=100, cy=200, r=0, rd_data all ones, wr_allow=1 → one write to addr 100. wr_data is all ones except bit 200=0. done pulses once; busy returns to 0.
2. Circle shape. cx=10, cy=50, r=3, rd_data all ones → writes to addr 7..13 in order:
   - col 10 clears bits 47..53.
   - col 8 and col 12 (h=2) clear bits 48..52.
   - col 9 and col 11 (h=2) clear bits 48..52.
   - col 7 and col 13 clear bit 50 only.
3. Left-edge clip. cx=1, cy=100, r=5 → writes only to addr 0..6 (7 writes). No address 1019..1023 ever appears.
4. Bottom clip. cx=300, cy=478, r=4, rd_data all ones → col 300 clears bits 474..479. Bits 480..511 stay 1 in every written word.
5. Write gating and ignored start. wr_allow=0 for 100 cycles mid-crater → wr_en stays 0 and the FSM holds in WRITE. After wr_allow=1, the write completes with the correct data. A start pulse issued while busy=1 produces no second crater.
6. Reset mid-operation. Assert reset during CALC of a r=20 crater → the next cycle shows busy=0, done=0, wr_en=0. No write follows. A fresh start then runs normally.
